keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Front-end stage for the two-function calculator: drives the 4x4 matrix keypad columns, samples the rows, debounces, and delivers one clean hex key code per physical press. Sits directly upstream of the input unit and control unit, which consume KeyCode/KeyValid in place of raw Row/Col lines. Handles scan timing, metastability, bounce, multi-key rejection and release detection.

Parameters:
SCAN_DIV, 1000, clocks each column is driven before its rows are sampled (>=3)
DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release (>=1)

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
Row  input  4  keypad rows, active-low, asynchronous to Clk
Col  output  4  keypad column drive, active-low one-hot
KeyCode  output  4  hex code of last accepted key
KeyValid  output  1  one-Clk strobe: KeyCode newly valid
KeyHeld  output  1  level: accepted key still down

Behaviour:
- Clocking: one clock (Clk); reset is asynchronous, active-high (Reset); all state reset at once.
- Reset values: Col=4'b1110, KeyCode=0, KeyValid=0, KeyHeld=0, FSM=IDLE, all counters 0, Row synchroniser flops=4'hF.
- Row passes a 2-flop synchroniser before any use.
- Scan: column index c=0..3, Col[c]=0 and others 1; each slot lasts SCAN_DIV clocks; synchronised Row sampled on the last clock of the slot; c wraps 3->0. One full scan = 4 slots = 4*SCAN_DIV clocks.
- Scan result at end of slot 3: NONE (no zero bits seen), SINGLE(k) (exactly one row/col intersection), MULTI (two or more).
- Key map (row r = Row[r], col c = Col[c]): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: *=E 0 #=F D.
- FSM, evaluated only at scan end:
  IDLE: SINGLE(k) -> DEBOUNCE, cand=k, cnt=1; else stay.
  DEBOUNCE: SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> PRESSED, KeyCode<=cand, KeyValid pulse. Any other result -> IDLE, cnt=0.
  PRESSED: KeyHeld=1. SINGLE(KeyCode) stays; NONE -> RELEASE, cnt=1; MULTI or different key -> stay, no strobe (roll-over rejected).
  RELEASE: NONE -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> IDLE, KeyHeld=0. Any key seen -> PRESSED, no strobe.
- DEBOUNCE_SCANS=1: IDLE goes straight to PRESSED with strobe on the first SINGLE scan; RELEASE goes straight to IDLE on the first NONE.
- KeyValid: high exactly one clock, the clock after the accepting scan end; never two strobes per press (unless typematic).
- KeyCode holds its value until the next accepted press; unaffected by release.
- Worst-case press latency: (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 clocks from stable contact.
- Reset mid-operation: immediate return to reset values; a key still held after reset is treated as a new press (strobes after debounce).
- Counters saturate; no wrap beyond DEBOUNCE_SCANS.

Optional Feature:
TYPEMATIC_EN: when defined, adds parameters REPEAT_DELAY_SCANS (default 50) and REPEAT_RATE_SCANS (default 10). In PRESSED with SINGLE(KeyCode), after REPEAT_DELAY_SCANS scans KeyValid re-pulses every REPEAT_RATE_SCANS scans with unchanged KeyCode; repeat counter clears on leaving PRESSED. When undefined: exactly one KeyValid per press, no extra logic.

Test Plan:
- SCAN_DIV=4, DEBOUNCE_SCANS=3; hold '5' (Row[1] low while Col[1]=0) stable -> one KeyValid, KeyCode=5, within 4*16+3 clocks; KeyHeld=1 until release.
- Bounce '9' (r2,c2) toggling every 7 clocks for 120 clocks, then stable -> exactly one KeyValid, KeyCode=9.
- Hold '1' and '6' together -> no KeyValid, KeyHeld=0; release '6' -> single strobe, KeyCode=1.
- Press '#', release for 1 scan, re-press -> one strobe total, KeyCode=F; release 3 scans, press 'D' -> second strobe, KeyCode=D.
- Assert Reset mid-DEBOUNCE -> Col=1110, KeyValid=0, KeyHeld=0, KeyCode=0 immediately; key still held -> strobe after 3 more scans.
- TYPEMATIC_EN, REPEAT_DELAY_SCANS=5, REPEAT_RATE_SCANS=2; hold 'A' for 15 scans after accept -> strobes at accept, +5, +7, +9, +11, +13, +15 scans, KeyCode=A.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, debounce, one KeyValid per press.
// Optional auto-repeat is enabled by defining TYPEMATIC_EN.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
`ifdef TYPEMATIC_EN
  ,
  parameter int REPEAT_DELAY_SCANS = 50,
  parameter int REPEAT_RATE_SCANS  = 10
`endif
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic       KeyHeld
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_N     = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t          state_q;
  logic [3:0]      row_meta_q, row_sync_q;
  logic [DW-1:0]   div_q;
  logic [1:0]      col_q;
  logic [1:0]      hits_q, hits_d;
  logic [3:0]      hit_key_q, key_d;
  logic [3:0]      cand_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      key_code_q;
  logic            key_valid_q, key_held_q;

`ifdef TYPEMATIC_EN
  localparam int RW = $clog2(REPEAT_DELAY_SCANS + REPEAT_RATE_SCANS + 1);
  localparam logic [RW-1:0] RPT_DLY = RW'(REPEAT_DELAY_SCANS);
  localparam logic [RW-1:0] RPT_END = RW'(REPEAT_DELAY_SCANS + REPEAT_RATE_SCANS);
  logic [RW-1:0] rpt_q;
`endif

  logic       slot_end, scan_end, res_none, res_single;
  logic [3:0] row_low;
  logic [2:0] slot_n;
  logic [1:0] slot_row;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign slot_end = (div_q == DIV_LAST);
  assign scan_end = slot_end && (col_q == 2'd3);
  assign row_low  = ~row_sync_q;
  assign slot_n   = 3'($countones(row_low));

  always_comb begin
    slot_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_low[r]) slot_row = 2'(r);
    end
  end

  // Fold the current slot into the running scan tally: 0 = none, 1 = single, 2 = multi.
  always_comb begin
    hits_d = hits_q;
    key_d  = hit_key_q;
    if (slot_n != 3'd0) begin
      if (hits_q == 2'd0 && slot_n == 3'd1) begin
        hits_d = 2'd1;
        key_d  = key_map(slot_row, col_q);
      end else begin
        hits_d = 2'd2;
      end
    end
  end

  assign res_none   = (hits_d == 2'd0);
  assign res_single = (hits_d == 2'd1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      div_q       <= '0;
      col_q       <= 2'd0;
      hits_q      <= 2'd0;
      hit_key_q   <= 4'h0;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef TYPEMATIC_EN
      rpt_q       <= '0;
`endif
    end else begin
      row_meta_q  <= Row;
      row_sync_q  <= row_meta_q;
      key_valid_q <= 1'b0;
      if (slot_end) begin
        div_q <= '0;
        col_q <= col_q + 2'd1;
        if (col_q == 2'd3) begin
          hits_q    <= 2'd0;
          hit_key_q <= 4'h0;
        end else begin
          hits_q    <= hits_d;
          hit_key_q <= key_d;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end

      if (scan_end) begin
        case (state_q)
          IDLE: begin
            if (res_single) begin
              cand_q <= key_d;
              if (DEBOUNCE_SCANS == 1) begin
                state_q     <= PRESSED;
                key_code_q  <= key_d;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                state_q <= DEBOUNCE;
                cnt_q   <= CW'(1);
              end
            end
          end
          DEBOUNCE: begin
            if (res_single && key_d == cand_q) begin
              if (cnt_q + 1'b1 == DB_N) begin
                state_q     <= PRESSED;
                cnt_q       <= '0;
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          PRESSED: begin
            if (res_none) begin
`ifdef TYPEMATIC_EN
              rpt_q <= '0;
`endif
              if (DEBOUNCE_SCANS == 1) begin
                state_q    <= IDLE;
                key_held_q <= 1'b0;
              end else begin
                state_q <= RELEASE;
                cnt_q   <= CW'(1);
              end
            end
`ifdef TYPEMATIC_EN
            else if (res_single && key_d == key_code_q) begin
              if (rpt_q + 1'b1 == RPT_END) begin
                rpt_q       <= RPT_DLY;
                key_valid_q <= 1'b1;
              end else begin
                rpt_q <= rpt_q + 1'b1;
                if (rpt_q + 1'b1 == RPT_DLY) key_valid_q <= 1'b1;
              end
            end
`endif
          end
          default: begin
            // Any contact during release debounce re-enters PRESSED silently.
            if (res_none) begin
              if (cnt_q + 1'b1 == DB_N) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                key_held_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end
          end
        endcase
      end
    end
  end

  assign Col      = ~(4'b0001 << col_q);
  assign KeyCode  = key_code_q;
  assign KeyValid = key_valid_q;
  assign KeyHeld  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives Row from Col and a pressed-key mask.
module tb_keypad_scanner;
  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  Row, Col, KeyCode;
  logic        KeyValid, KeyHeld;
  logic [15:0] pressed;
  int          n_cmp = 0;
  int          n_err = 0;
  int          strobes = 0;
  int          s0, n;

  always #5 Clk = ~Clk;

  // Key at row r, column c is bit r*4+c; a closed key pulls its row low while its column is driven.
  always_comb begin
    Row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !Col[c]) Row[r] = 1'b0;
  end

  always @(posedge Clk) if (!Reset && KeyValid === 1'b1) strobes++;

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_SCANS(DB)
`ifdef TYPEMATIC_EN
    ,
    .REPEAT_DELAY_SCANS(5),
    .REPEAT_RATE_SCANS(2)
`endif
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Row(Row),
    .Col(Col),
    .KeyCode(KeyCode),
    .KeyValid(KeyValid),
    .KeyHeld(KeyHeld)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge Clk);
  endtask

  // Leaves the bench on the negedge of the first clock of a fresh scan (column 0 just driven).
  task automatic align();
    int k;
    k = 0;
    while (Col !== 4'b0111 && k < 100) begin @(negedge Clk); k++; end
    while (Col !== 4'b1110 && k < 200) begin @(negedge Clk); k++; end
    check("align", 32'(Col), 32'hE);
  endtask

  initial begin
    Reset   = 1'b1;
    pressed = 16'h0;
    tick(3);
    check("rst_col",   32'(Col),      32'hE);
    check("rst_code",  32'(KeyCode),  32'h0);
    check("rst_valid", 32'(KeyValid), 32'h0);
    check("rst_held",  32'(KeyHeld),  32'h0);
    Reset = 1'b0;
    tick(4 * SCAN);
    check("idle_strobes", 32'(strobes), 32'd0);
    check("idle_held",    32'(KeyHeld), 32'h0);

    // '5' held stable: one strobe within (DB+1)*4*SD+3 clocks
    s0 = strobes;
    pressed[5] = 1'b1;
    n = 0;
    while (n < (DB + 1) * SCAN + 3 && KeyValid !== 1'b1) begin @(negedge Clk); n++; end
    check("p5_latency", 32'(KeyValid), 32'h1);
    check("p5_code",    32'(KeyCode),  32'h5);
    tick(10 * SCAN);
    check("p5_once", 32'(strobes - s0), 32'd1);
    check("p5_held", 32'(KeyHeld),      32'h1);
    pressed[5] = 1'b0;
    tick(5 * SCAN);
    check("p5_release", 32'(KeyHeld),      32'h0);
    check("p5_keep",    32'(KeyCode),      32'h5);
    check("p5_norel",   32'(strobes - s0), 32'd1);

    // '9' bouncing every 7 clocks for 120 clocks, then stable
    align();
    s0 = strobes;
    for (int j = 0; j < 120; j++) begin
      pressed[10] = ((j / 7) % 2 == 0);
      @(negedge Clk);
    end
    pressed[10] = 1'b1;
    tick(8 * SCAN);
    check("b9_once", 32'(strobes - s0), 32'd1);
    check("b9_code", 32'(KeyCode),      32'h9);
    check("b9_held", 32'(KeyHeld),      32'h1);
    pressed = 16'h0;
    tick(5 * SCAN);

    // '1' and '6' together are rejected; dropping '6' accepts '1'
    s0 = strobes;
    pressed[0] = 1'b1;
    pressed[6] = 1'b1;
    tick(8 * SCAN);
    check("multi_nostrobe", 32'(strobes - s0), 32'd0);
    check("multi_noheld",   32'(KeyHeld),      32'h0);
    pressed[6] = 1'b0;
    tick(6 * SCAN);
    check("single1_once", 32'(strobes - s0), 32'd1);
    check("single1_code", 32'(KeyCode),      32'h1);
    pressed = 16'h0;
    tick(5 * SCAN);

    // '#' with a one-scan gap is one press; a three-scan release then 'D' is a new press
    s0 = strobes;
    pressed[14] = 1'b1;
    tick(6 * SCAN);
    check("hash_once", 32'(strobes - s0), 32'd1);
    check("hash_code", 32'(KeyCode),      32'hF);
    align();
    pressed[14] = 1'b0;
    tick(SCAN);
    pressed[14] = 1'b1;
    tick(6 * SCAN);
    check("hash_gap_nostrobe", 32'(strobes - s0), 32'd1);
    check("hash_gap_held",     32'(KeyHeld),      32'h1);
    align();
    pressed[14] = 1'b0;
    tick(3 * SCAN - 1);
    check("hash_rel_edge_held", 32'(KeyHeld), 32'h1);
    tick(1);
    check("hash_rel_done", 32'(KeyHeld), 32'h0);
    pressed[15] = 1'b1;
    tick(6 * SCAN);
    check("d_second", 32'(strobes - s0), 32'd2);
    check("d_code",   32'(KeyCode),      32'hD);
    pressed = 16'h0;
    tick(5 * SCAN);

    // Reset during DEBOUNCE of '2'; the held key is re-accepted three scans after reset
    align();
    pressed[1] = 1'b1;
    tick(40);
    Reset = 1'b1;
    #1;
    check("mid_rst_col",   32'(Col),      32'hE);
    check("mid_rst_valid", 32'(KeyValid), 32'h0);
    check("mid_rst_held",  32'(KeyHeld),  32'h0);
    check("mid_rst_code",  32'(KeyCode),  32'h0);
    tick(2);
    s0 = strobes;
    Reset = 1'b0;
    n = 0;
    while (n < 200 && KeyValid !== 1'b1) begin @(negedge Clk); n++; end
    check("post_rst_latency", 32'(n), 32'd48);
    check("post_rst_code",    32'(KeyCode), 32'h2);
    tick(4 * SCAN);
    check("post_rst_once", 32'(strobes - s0), 32'd1);
    check("post_rst_held", 32'(KeyHeld),      32'h1);
    pressed = 16'h0;
    tick(5 * SCAN);

`ifdef TYPEMATIC_EN
    // 'A' held 15 scans past accept: strobes at +0,+5,+7,+9,+11,+13,+15 scans
    align();
    s0 = strobes;
    pressed[3] = 1'b1;
    tick(3 * SCAN + 15 * SCAN + 4);
    check("rpt_count", 32'(strobes - s0), 32'd7);
    check("rpt_code",  32'(KeyCode),      32'hA);
    pressed = 16'h0;
    tick(5 * SCAN);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
